sfq_xor_driver: RTL and testbench
=================================

Name: sfq_xor_driver

Overview:
Synchronous transmitter/receiver front end that exercises a toggle-encoded (SFQ-style) clocked XOR cell. It accepts operand pairs over a valid/ready handshake and emits toggle pulses on the cell's a, b and clk inputs, spacing them to respect the cell's hold windows. It then decodes the cell's toggle-encoded output back to a level result and checks it against a XOR b. It sits in integration benches and on-chip test wrappers between a pattern source and the pulse-domain cell.

Parameters:
AB_GAP, 3, cycles between a-toggle and b-toggle when both operands are 1 (min 1)
CLK_GAP, 5, cycles from last data toggle to clk toggle (min 1)
OUT_WAIT, 8, cycles from clk toggle to sampling sfq_out (min 1)
STARTUP, 4, cycles after reset before the first transaction is accepted
ERRW, 16, width of saturating mismatch counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  driver can accept a pair
in_a  in  1  operand a (level)
in_b  in  1  operand b (level)
sfq_a  out  1  toggle-encoded a pulse line to cell
sfq_b  out  1  toggle-encoded b pulse line to cell
sfq_clk  out  1  toggle-encoded clock pulse line to cell
sfq_out  in  1  toggle-encoded cell output
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_bit  out  1  decoded cell result (1 = sfq_out toggled)
res_err  out  1  res_bit != (a XOR b) for this transaction
err_count  out  ERRW  saturating count of mismatches

Behaviour:
- Clock is clk; reset is synchronous, active-high. All state updates on rising clk.
- Reset: sfq_a=sfq_b=sfq_clk=0, in_ready=0, res_valid=0, res_bit=0, res_err=0, err_count=0, out_ref<=sfq_out, FSM=BOOT, counter=0.
- Pulse = one level toggle of an sfq_* line. Line levels are never reset except by rst.
- FSM states and transitions:
  BOOT: count STARTUP cycles -> IDLE.
  IDLE: in_ready=1. On in_valid&in_ready, latch a,b -> DATA_A.
  DATA_A: if a, toggle sfq_a. If a&b -> GAP_AB, else -> DATA_B the same cycle.
  GAP_AB: wait AB_GAP cycles -> DATA_B.
  DATA_B: if b, toggle sfq_b -> GAP_CLK.
  GAP_CLK: wait CLK_GAP cycles (counts even when a=b=0) -> CLK.
  CLK: toggle sfq_clk -> WAIT_OUT.
  WAIT_OUT: wait OUT_WAIT cycles, then sample. res_bit = sfq_out ^ out_ref; out_ref <= sfq_out; res_err = res_bit ^ (a^b) -> RESP.
  RESP: res_valid=1, outputs held stable until res_ready. On handshake: res_valid=0, err_count += res_err (saturate at all-ones) -> IDLE.
- in_ready is 1 only in IDLE, so at most one transaction is in flight. Back-to-back throughput is 1 + (a&b?AB_GAP:0) + CLK_GAP + 1 + OUT_WAIT + 1 cycles minimum, plus res_ready stall.
- a=b=1 drives the cell through its toggle-cancel path, so the expected result is 0. AB_GAP enforces the a->b spacing.
- Multiple sfq_out toggles inside the wait window are resolved by parity only. No glitch detection.
- rst asserted in any state aborts the transaction immediately and applies reset values. Any pending result is lost and err_count clears.
- err_count at max stays at max.

Decomposition:
- Shared package sfq_drv_pkg holds the FSM state enum (BOOT, IDLE, DATA_A, GAP_AB, DATA_B, GAP_CLK, CLK, WAIT_OUT, RESP) and a parameter sanity function (all gaps >= 1).
- One sub-module: sfq_toggle_line, a single-bit toggle register with synchronous reset and a fire input. It is instantiated three times for sfq_a, sfq_b and sfq_clk.

Test Plan:
- Reset then in_valid with a=1,b=0; cell model toggles out -> sfq_a toggles once, sfq_b unchanged, sfq_clk toggles CLK_GAP cycles later, res_bit=1, res_err=0.
- a=1,b=1 -> sfq_b toggles exactly AB_GAP cycles after sfq_a; cell model gives no out toggle; res_bit=0, res_err=0.
- a=0,b=0 with faulty model toggling out -> res_bit=1, res_err=1; err_count 0->1 on res handshake.
- Hold res_ready=0 for 10 cycles -> res_valid, res_bit, res_err stable; in_ready=0 throughout; release accepts the next pair next cycle.
- Pulse rst during GAP_CLK -> next cycle all sfq_* =0, res_valid=0, err_count=0; in_ready=0 for STARTUP cycles, then 1.
- ERRW=2, force 5 mismatches -> err_count saturates at 3.

Source files
------------

// File: rtl/sfq_drv_pkg.sv
// Shared definitions for the SFQ XOR-cell driver: FSM states and parameter sanity check.
package sfq_drv_pkg;

    typedef enum logic [3:0] {
        BOOT,
        IDLE,
        DATA_A,
        GAP_AB,
        DATA_B,
        GAP_CLK,
        CLK,
        WAIT_OUT,
        RESP
    } drv_state_t;

    function automatic bit gaps_ok(input int ab_gap, input int clk_gap, input int out_wait);
        return (ab_gap >= 1) && (clk_gap >= 1) && (out_wait >= 1);
    endfunction

endpackage

// File: rtl/sfq_toggle_line.sv
// Single toggle-encoded pulse line: each fire flips the level; only reset returns it to 0.
module sfq_toggle_line (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic line
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= 1'b0;
        end else if (fire) begin
            line <= ~line;
        end
    end

endmodule

// File: rtl/sfq_xor_driver.sv
// Drives a toggle-encoded clocked XOR cell with spaced a/b/clk pulses and checks the
// decoded output against a XOR b, keeping a saturating mismatch count.
module sfq_xor_driver
    import sfq_drv_pkg::*;
#(
    parameter int AB_GAP   = 3,
    parameter int CLK_GAP  = 5,
    parameter int OUT_WAIT = 8,
    parameter int STARTUP  = 4,
    parameter int ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_a,
    input  logic            in_b,
    output logic            sfq_a,
    output logic            sfq_b,
    output logic            sfq_clk,
    input  logic            sfq_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_bit,
    output logic            res_err,
    output logic [ERRW-1:0] err_count
);

    if (!gaps_ok(AB_GAP, CLK_GAP, OUT_WAIT)) begin : g_bad_params
        $error("sfq_xor_driver: AB_GAP, CLK_GAP and OUT_WAIT must all be >= 1");
    end

    // The toggle state itself is one pulse cycle, so each gap state lasts GAP-1 cycles
    // and is skipped entirely when the gap is 1.
    localparam drv_state_t AFTER_A    = (AB_GAP  > 1) ? GAP_AB  : DATA_B;
    localparam drv_state_t AFTER_DATA = (CLK_GAP > 1) ? GAP_CLK : CLK;

    drv_state_t  state;
    logic [31:0] cnt;
    logic        op_a;
    logic        op_b;
    logic        out_ref;
    logic        fire_a;
    logic        fire_b;
    logic        fire_clk;

    // When a&b is false, the b toggle shares the DATA_A cycle.
    always_comb begin
        fire_a   = 1'b0;
        fire_b   = 1'b0;
        fire_clk = 1'b0;
        case (state)
            DATA_A: begin
                fire_a = op_a;
                fire_b = op_b & ~op_a;
            end
            DATA_B:  fire_b   = op_b;
            CLK:     fire_clk = 1'b1;
            default: ;
        endcase
    end

    sfq_toggle_line u_line_a (
        .clk  (clk),
        .rst  (rst),
        .fire (fire_a),
        .line (sfq_a)
    );

    sfq_toggle_line u_line_b (
        .clk  (clk),
        .rst  (rst),
        .fire (fire_b),
        .line (sfq_b)
    );

    sfq_toggle_line u_line_clk (
        .clk  (clk),
        .rst  (rst),
        .fire (fire_clk),
        .line (sfq_clk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            cnt       <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_bit   <= 1'b0;
            res_err   <= 1'b0;
            err_count <= '0;
            out_ref   <= sfq_out;
            op_a      <= 1'b0;
            op_b      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (cnt + 32'd1 >= 32'(STARTUP)) begin
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        in_ready <= 1'b0;
                        state    <= DATA_A;
                    end
                end
                DATA_A: begin
                    cnt   <= '0;
                    state <= (op_a && op_b) ? AFTER_A : AFTER_DATA;
                end
                GAP_AB: begin
                    if (cnt + 32'd2 >= 32'(AB_GAP)) begin
                        cnt   <= '0;
                        state <= DATA_B;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA_B: begin
                    cnt   <= '0;
                    state <= AFTER_DATA;
                end
                GAP_CLK: begin
                    if (cnt + 32'd2 >= 32'(CLK_GAP)) begin
                        cnt   <= '0;
                        state <= CLK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CLK: begin
                    cnt   <= '0;
                    state <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (cnt + 32'd1 >= 32'(OUT_WAIT)) begin
                        cnt       <= '0;
                        res_bit   <= sfq_out ^ out_ref;
                        res_err   <= (sfq_out ^ out_ref) ^ (op_a ^ op_b);
                        out_ref   <= sfq_out;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (res_err && (err_count != '1)) begin
                            err_count <= err_count + ERRW'(1);
                        end
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfq_xor_driver.sv
// Bench for sfq_xor_driver: behavioural XOR-cell model, table vectors, random transactions,
// reset abort and counter saturation (second instance with a 2-bit counter).
module tb_sfq_xor_driver;

    localparam int AB_GAP   = 3;
    localparam int CLK_GAP  = 5;
    localparam int OUT_WAIT = 8;
    localparam int STARTUP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_a = 1'b0;
    logic in_b = 1'b0;
    logic sfq_out = 1'b0;
    logic res_ready = 1'b0;

    logic        in_ready, sfq_a, sfq_b, sfq_clk, res_valid, res_bit, res_err;
    logic [15:0] err_count;
    logic        in_ready2, sfq_a2, sfq_b2, sfq_clk2, res_valid2, res_bit2, res_err2;
    logic [1:0]  err_count2;

    sfq_xor_driver #(
        .AB_GAP(AB_GAP), .CLK_GAP(CLK_GAP), .OUT_WAIT(OUT_WAIT), .STARTUP(STARTUP), .ERRW(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .sfq_a(sfq_a), .sfq_b(sfq_b), .sfq_clk(sfq_clk), .sfq_out(sfq_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit), .res_err(res_err),
        .err_count(err_count)
    );

    sfq_xor_driver #(
        .AB_GAP(AB_GAP), .CLK_GAP(CLK_GAP), .OUT_WAIT(OUT_WAIT), .STARTUP(STARTUP), .ERRW(2)
    ) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
        .sfq_a(sfq_a2), .sfq_b(sfq_b2), .sfq_clk(sfq_clk2), .sfq_out(sfq_out),
        .res_valid(res_valid2), .res_ready(res_ready), .res_bit(res_bit2), .res_err(res_err2),
        .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Cell model: remembers data pulses since the last clk pulse; on a clk pulse it toggles
    // sfq_out when exactly one data line pulsed (inverted under cell_fault), plus two extra
    // glitch toggles when cell_glitch is set. Also timestamps every pulse on the DUT lines.
    logic pa, pb, pc, da, db;
    logic cell_fault = 1'b0;
    logic cell_glitch = 1'b0;
    int   pend;
    int   t_a, t_b, t_c;
    int   na = 0, nb = 0, nc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pa = 1'b0; pb = 1'b0; pc = 1'b0; da = 1'b0; db = 1'b0; pend = 0;
        end else begin
            if (sfq_a !== pa) begin pa = sfq_a; da = ~da; t_a = cyc; na++; end
            if (sfq_b !== pb) begin pb = sfq_b; db = ~db; t_b = cyc; nb++; end
            if (sfq_clk !== pc) begin
                pc   = sfq_clk;
                t_c  = cyc;
                nc++;
                pend = ((da ^ db ^ cell_fault) ? 1 : 0) + (cell_glitch ? 2 : 0);
                da   = 1'b0;
                db   = 1'b0;
            end else if (pend > 0) begin
                sfq_out = ~sfq_out;
                pend--;
            end
        end
    end

    int total = 0;
    int bad = 0;
    int nfault = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check_reset_state();
        chk("rst_lines", {sfq_a, sfq_b, sfq_clk}, 0);
        chk("rst_ctrl", {in_ready, res_valid, res_bit, res_err}, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_dut2", {sfq_a2, sfq_b2, sfq_clk2, in_ready2, res_valid2, err_count2}, 0);
    endtask

    // Call right after the last reset edge with rst already released.
    task automatic check_boot();
        for (int i = 1; i < STARTUP; i++) begin
            tick();
            chk("boot_in_ready_low", in_ready, 0);
        end
        tick();
        chk("boot_in_ready_high", in_ready, 1);
    endtask

    task automatic run_txn(input logic a, input logic b, input logic f, input logic g,
                           input int stall, input logic eb, input logic ee);
        int acc, tv, t_data, a0, b0, c0, k;
        cell_fault  = f;
        cell_glitch = g;
        k = 0;
        while (!in_ready && k < 300) begin tick(); k++; end
        if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
        in_valid = 1'b1; in_a = a; in_b = b;
        a0 = na; b0 = nb; c0 = nc;
        tick();
        in_valid = 1'b0;
        acc = cyc;
        chk("in_ready_after_accept", in_ready, 0);
        k = 0;
        while (!res_valid && k < 300) begin tick(); k++; end
        if (!res_valid) begin chk("res_valid_timeout", 0, 1); return; end
        tv = cyc;
        t_data = acc + 1 + ((a && b) ? AB_GAP : 0);
        chk("a_pulses", na - a0, int'(a));
        chk("b_pulses", nb - b0, int'(b));
        chk("clk_pulses", nc - c0, 1);
        if (a) chk("a_time", t_a, acc + 1);
        if (b) chk("b_time", t_b, t_data);
        if (a && b) chk("ab_gap", t_b - t_a, AB_GAP);
        chk("clk_time", t_c, t_data + CLK_GAP);
        chk("res_time", tv, t_c + OUT_WAIT);
        chk("res_bit", res_bit, int'(eb));
        chk("res_err", res_err, int'(ee));
        chk("dut2_res", {res_valid2, res_bit2, res_err2}, {1'b1, eb, ee});
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_hold", {res_valid, res_bit, res_err, in_ready}, {1'b1, eb, ee, 1'b0});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        nfault += int'(ee);
        chk("res_valid_drop", res_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("err_count", err_count, sat(nfault, 65535));
        chk("err_count_sat2", err_count2, sat(nfault, 3));
    endtask

    typedef struct {
        logic a, b, f, g;
        int   stall;
        logic eb, ee;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic ra, rb, rf, rg;
        int   acc;

        //          a     b     fault glitch stall  res_bit res_err
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 0,  1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2,  1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        check_boot();

        foreach (tbl[i]) begin
            run_txn(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].g, tbl[i].stall, tbl[i].eb, tbl[i].ee);
        end

        for (int i = 0; i < 24; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 3) == 0);
            rg = ($urandom_range(0, 4) == 0);
            run_txn(ra, rb, rf, rg, int'($urandom_range(0, 3)), ra ^ rb ^ rf, rf);
        end

        // Abort a transaction from inside the clk gap.
        cell_fault = 1'b0;
        cell_glitch = 1'b0;
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        chk("pre_abort_err_nonzero", (err_count != 0) ? 1 : 0, 1);
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
        tick();
        in_valid = 1'b0;
        acc = cyc;
        while (cyc < acc + 1 + AB_GAP + 2) tick();
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        nfault = 0;
        check_boot();

        // Five mismatches: 16-bit counter reaches 5, 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        end
        chk("final_err_count", err_count, 5);
        chk("final_err_count2", err_count2, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
